// File: rtl/seq_multiplier_n.sv
// Sequential shift-add multiplier, one partial product per clock.
// Signed operands are handled as magnitudes with the sign applied at the end.
module seq_multiplier_n #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nx;
  logic [2*WIDTH-1:0] pp;
  logic [CW-1:0]      cnt;
  logic               sign_neg;
  logic               last;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // -2^(WIDTH-1) negates to itself, which reads correctly as unsigned
  always_comb begin
    a_mag  = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag  = (is_signed && b[WIDTH-1]) ? -b : b;
    pp     = mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
    acc_nx = acc + pp;
    last   = (cnt == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = CALC;
      CALC:    if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      sign_neg <= 1'b0;
      product  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= a_mag;
            mplier   <= b_mag;
            sign_neg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc      <= '0;
            cnt      <= '0;
          end
        end
        CALC: begin
          acc    <= acc_nx;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last) product <= sign_neg ? -acc_nx : acc_nx;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Bench for seq_multiplier_n: latency model plus directed vectors.
// A free-running compare process checks handshake outputs every cycle.
module tb_seq_multiplier_n;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           is_signed = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] product;
  logic           busy;

  int checks = 0;
  int errors = 0;
  bit go = 1'b0;

  seq_multiplier_n #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input logic s);
    longint xi, yi;
    xi = s ? longint'($signed(x)) : longint'(x);
    yi = s ? longint'($signed(y)) : longint'(y);
    return (2*W)'(xi * yi);
  endfunction

  // model: cycles left in the computation, result pending/visible
  int             m_left = 0;
  bit             m_outv = 1'b0;
  bit             m_rflag = 1'b1;
  logic [2*W-1:0] m_pend = '0;
  logic [2*W-1:0] m_prod = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left  = 0;
      m_outv  = 1'b0;
      m_rflag = 1'b1;
      m_prod  = '0;
    end else if (m_outv) begin
      if (out_ready) m_outv = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_outv  = 1'b1;
        m_rflag = 1'b0;
        m_prod  = m_pend;
      end
    end else if (in_valid) begin
      m_pend = ref_mul(a, b, is_signed);
      m_left = W;
    end
  end

  always @(negedge clk) begin
    if (go) begin
      chk("in_ready", 32'(in_ready),
          32'(!rst && m_left == 0 && !m_outv));
      chk("out_valid", 32'(out_valid), 32'(m_outv));
      chk("busy", 32'(busy), 32'(m_left > 0 || m_outv));
      if (m_outv || m_rflag)
        chk("product", 32'(product), 32'(m_prod));
    end
  end

  task automatic send(input logic [W-1:0] x,
                      input logic [W-1:0] y,
                      input logic s);
    @(posedge clk); #1;
    in_valid  = 1'b1;
    a         = x;
    b         = y;
    is_signed = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) chk("timeout", 32'(lat), 32'(W));
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  int             lat;
  logic [2*W-1:0] p0;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst product", 32'(product), 32'd0);
    go  = 1'b1;
    rst = 1'b0;
    #1;
    chk("post rst in_ready", 32'(in_ready), 32'd1);

    send(8'd255, 8'd255, 1'b0);
    wait_valid(lat);
    chk("umax", 32'(product), 32'h0000_FE01);
    chk("umax latency", 32'(lat), 32'd8);
    handshake();

    send(8'h80, 8'h80, 1'b1);
    wait_valid(lat);
    chk("smin sq", 32'(product), 32'h0000_4000);
    handshake();

    send(8'hFD, 8'h05, 1'b1);
    wait_valid(lat);
    chk("s -3*5", 32'(product), 32'h0000_FFF1);
    handshake();

    send(8'hFD, 8'h05, 1'b0);
    wait_valid(lat);
    chk("u 253*5", 32'(product), 32'h0000_04F1);
    p0 = product;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp product", 32'(product), 32'(p0));
      chk("bp out_valid", 32'(out_valid), 32'd1);
      chk("bp in_ready", 32'(in_ready), 32'd0);
    end
    handshake();
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    chk("bp release out_valid", 32'(out_valid), 32'd0);

    @(posedge clk); #1;
    in_valid  = 1'b1;
    a         = 8'd3;
    b         = 8'd9;
    is_signed = 1'b0;
    @(posedge clk); #1;
    a = 8'd11;
    b = 8'd13;
    wait_valid(lat);
    chk("overlap first", 32'(product), 32'd27);
    handshake();
    chk("overlap idle busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("overlap accept busy", 32'(busy), 32'd1);
    wait_valid(lat);
    chk("overlap second", 32'(product), 32'd143);
    chk("overlap latency", 32'(lat), 32'd8);
    handshake();

    send(8'd100, 8'd50, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst product", 32'(product), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst in_ready rel", 32'(in_ready), 32'd1);

    send(8'd7, 8'd6, 1'b0);
    wait_valid(lat);
    chk("7*6", 32'(product), 32'd42);
    handshake();

    send(8'h00, 8'hFF, 1'b1);
    wait_valid(lat);
    chk("zero", 32'(product), 32'd0);
    chk("zero latency", 32'(lat), 32'd8);
    handshake();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
